// File: rtl/adder12_window_loader.sv
// rtl/adder12_window_loader.sv - 8-deep sliding sample window feeding the 8-input adder
// Each accepted sample shifts in at n0. win_valid marks every DECIM-th full window.
module adder12_window_loader #(
  parameter int WIDTH = 12,
  parameter int DECIM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] n0,
  output logic [WIDTH-1:0] n1,
  output logic [WIDTH-1:0] n2,
  output logic [WIDTH-1:0] n3,
  output logic [WIDTH-1:0] n4,
  output logic [WIDTH-1:0] n5,
  output logic [WIDTH-1:0] n6,
  output logic [WIDTH-1:0] n7,
  output logic             win_valid,
  output logic [3:0]       fill_count
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(DECIM - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_win [8];
  logic [3:0]       r_fill;
  logic [DW-1:0]    r_dcnt;
  logic             r_win_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_win[i] <= '0;
      r_fill      <= 4'd0;
      r_dcnt      <= '0;
      r_win_valid <= 1'b0;
      r_state     <= EMPTY;
    end else if (flush) begin
      // flush wins over a simultaneous sample, which is dropped
      for (int i = 0; i < 8; i++) r_win[i] <= '0;
      r_fill      <= 4'd0;
      r_dcnt      <= '0;
      r_win_valid <= 1'b0;
      r_state     <= EMPTY;
    end else if (din_valid) begin
      for (int i = 7; i > 0; i--) r_win[i] <= r_win[i-1];
      r_win[0] <= din;
      case (r_state)
        EMPTY: begin
          r_fill      <= 4'd1;
          r_win_valid <= 1'b0;
          r_state     <= FILLING;
        end
        FILLING: begin
          r_fill <= r_fill + 4'd1;
          if (r_fill == 4'd7) begin
            r_win_valid <= 1'b1;
            r_dcnt      <= '0;
            r_state     <= FULL;
          end else begin
            r_win_valid <= 1'b0;
          end
        end
        FULL: begin
          if (r_dcnt == DCNT_MAX) begin
            r_win_valid <= 1'b1;
            r_dcnt      <= '0;
          end else begin
            r_win_valid <= 1'b0;
            r_dcnt      <= r_dcnt + DW'(1);
          end
        end
        default: begin
          r_fill      <= 4'd0;
          r_win_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
    end else begin
      r_win_valid <= 1'b0;
    end
  end

  assign n0         = r_win[0];
  assign n1         = r_win[1];
  assign n2         = r_win[2];
  assign n3         = r_win[3];
  assign n4         = r_win[4];
  assign n5         = r_win[5];
  assign n6         = r_win[6];
  assign n7         = r_win[7];
  assign win_valid  = r_win_valid;
  assign fill_count = r_fill;

endmodule

// File: tb/tb_adder12_window_loader.sv
// tb/tb_adder12_window_loader.sv - randomized and directed checks of the window loader
// Two instances (DECIM=1 and DECIM=4) share stimulus and are compared to a sample-history model.
module tb_adder12_window_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        flush = 1'b0;

  logic [11:0] a_n [8];
  logic [11:0] b_n [8];
  logic        a_wv, b_wv;
  logic [3:0]  a_fill, b_fill;

  int n_checks = 0;
  int n_fail   = 0;
  int a_pulses = 0;
  int b_pulses = 0;

  always #5 clk = ~clk;

  adder12_window_loader #(.WIDTH(12), .DECIM(1)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
    .n0(a_n[0]), .n1(a_n[1]), .n2(a_n[2]), .n3(a_n[3]),
    .n4(a_n[4]), .n5(a_n[5]), .n6(a_n[6]), .n7(a_n[7]),
    .win_valid(a_wv), .fill_count(a_fill)
  );

  adder12_window_loader #(.WIDTH(12), .DECIM(4)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
    .n0(b_n[0]), .n1(b_n[1]), .n2(b_n[2]), .n3(b_n[3]),
    .n4(b_n[4]), .n5(b_n[5]), .n6(b_n[6]), .n7(b_n[7]),
    .win_valid(b_wv), .fill_count(b_fill)
  );

  // Model: history of accepted samples (newest first) and accepts since last clear.
  logic [11:0] hist[$];
  int          acc = 0;
  bit          last_acc = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      hist.delete();
      acc      = 0;
      last_acc = 1'b0;
    end else if (din_valid) begin
      hist.push_front(din);
      if (hist.size() > 8) void'(hist.pop_back());
      acc++;
      last_acc = 1'b1;
    end else begin
      last_acc = 1'b0;
    end
  end

  function automatic logic [95:0] exp_win();
    logic [95:0] w = '0;
    for (int k = 0; k < 8; k++)
      if (k < hist.size()) w[k*12 +: 12] = hist[k];
    return w;
  endfunction

  function automatic logic [3:0] exp_fill();
    return (acc > 8) ? 4'd8 : 4'(acc);
  endfunction

  function automatic logic exp_wv(input int d);
    return last_acc && (acc >= 8) && (((acc - 8) % d) == 0);
  endfunction

  function automatic logic [95:0] pack(input logic [11:0] n [8]);
    logic [95:0] w;
    for (int k = 0; k < 8; k++) w[k*12 +: 12] = n[k];
    return w;
  endfunction

  function automatic int wsum(input logic [95:0] w);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'($signed(w[k*12 +: 12]));
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("a_window", pack(a_n), exp_win());
    check("a_fill", a_fill, exp_fill());
    check("a_win_valid", a_wv, exp_wv(1));
    check("b_window", pack(b_n), exp_win());
    check("b_fill", b_fill, exp_fill());
    check("b_win_valid", b_wv, exp_wv(4));
    if (a_wv) a_pulses++;
    if (b_wv) b_pulses++;
  end

  task automatic accept(input logic [11:0] d);
    @(negedge clk); #1;
    din = d; din_valid = 1'b1; flush = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk); #1;
    din_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush(input logic v, input logic [11:0] d);
    @(negedge clk); #1;
    din = d; din_valid = v; flush = 1'b1;
    @(negedge clk); #1;
    din_valid = 1'b0; flush = 1'b0;
  endtask

  int p0;

  initial begin
    // 1: async reset between edges
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    accept(12'h123);
    accept(12'h456);
    idle();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_fill", a_fill, 4'd0);
    check("rst_async_win", pack(a_n), 96'd0);
    check("rst_async_wv", a_wv, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_fill", b_fill, 4'd0);
    check("rst_hold_win", pack(b_n), 96'd0);
    @(negedge clk); #1 rst = 1'b0;

    // 2: ramp 1..8, then 9
    p0 = a_pulses;
    for (int i = 1; i <= 8; i++) accept(12'(i));
    idle();
    check("ramp_n0", a_n[0], 12'h008);
    check("ramp_n7", a_n[7], 12'h001);
    check("ramp_fill", a_fill, 4'd8);
    check("ramp_wv", a_wv, 1'b1);
    check("ramp_sum", wsum(pack(a_n)), 36);
    accept(12'h009);
    idle();
    check("ramp9_n0", a_n[0], 12'h009);
    check("ramp9_n7", a_n[7], 12'h002);
    check("ramp9_wv", a_wv, 1'b1);
    check("ramp_pulses", a_pulses - p0, 2);

    // 3: most-negative samples with gapped valid
    do_flush(1'b0, 12'h000);
    p0 = a_pulses;
    for (int i = 0; i < 8; i++) begin
      accept(12'h800);
      idle();
    end
    check("neg_sum", wsum(pack(a_n)), -16384);
    check("neg_fill", a_fill, 4'd8);
    check("neg_pulses", a_pulses - p0, 1);

    // 4: flush mid-fill drops the simultaneous sample
    for (int i = 0; i < 5; i++) accept(12'($urandom));
    do_flush(1'b1, 12'h7FF);
    check("flush_fill", a_fill, 4'd0);
    check("flush_win", pack(a_n), 96'd0);
    p0 = a_pulses;
    for (int i = 0; i < 7; i++) accept(12'($urandom));
    idle();
    check("flush_7_pulses", a_pulses - p0, 0);
    accept(12'h0AA);
    idle();
    check("flush_8_pulses", a_pulses - p0, 1);

    // 5: DECIM=4 pulses after accepts 8, 12, 16
    do_flush(1'b0, 12'h000);
    p0 = b_pulses;
    for (int i = 0; i < 16; i++) accept(12'($urandom));
    idle();
    check("decim4_pulses", b_pulses - p0, 3);

    // 6: reset while full and streaming
    for (int i = 0; i < 13; i++) accept(12'($urandom));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_fill", a_fill, 4'd0);
    check("rst_mid_win", pack(a_n), 96'd0);
    @(negedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    p0 = a_pulses;
    for (int i = 0; i < 7; i++) accept(12'h100 + 12'(i));
    idle();
    check("resume_7_pulses", a_pulses - p0, 0);
    accept(12'h107);
    idle();
    check("resume_8_pulses", a_pulses - p0, 1);
    check("resume_n7", a_n[7], 12'h100);
    check("resume_n0", a_n[0], 12'h107);

    // random soak
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      din       = 12'($urandom);
      din_valid = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 2);
    end
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
